// File: rtl/ifetch_queue_unit_pkg.sv
// Shared opcode constants, optype encodings, issue-queue entry layout and the
// fetch-side RV32I decoder used by ifetch_queue_unit.
package ifetch_queue_unit_pkg;

  localparam logic [6:0] LUIOP   = 7'b0110111;
  localparam logic [6:0] AUIPCOP = 7'b0010111;
  localparam logic [6:0] JALOP   = 7'b1101111;
  localparam logic [6:0] JALROP  = 7'b1100111;
  localparam logic [6:0] BOP     = 7'b1100011;
  localparam logic [6:0] LOADOP  = 7'b0000011;
  localparam logic [6:0] STOREOP = 7'b0100011;
  localparam logic [6:0] IMMOP   = 7'b0010011;
  localparam logic [6:0] REGOP   = 7'b0110011;

  typedef enum logic [5:0] {
    OPT_NONE  = 6'd0,  OPT_LUI   = 6'd1,  OPT_AUIPC = 6'd2,  OPT_JAL   = 6'd3,
    OPT_JALR  = 6'd4,  OPT_BEQ   = 6'd5,  OPT_BNE   = 6'd6,  OPT_BLT   = 6'd7,
    OPT_BGE   = 6'd8,  OPT_BLTU  = 6'd9,  OPT_BGEU  = 6'd10, OPT_LB    = 6'd11,
    OPT_LH    = 6'd12, OPT_LW    = 6'd13, OPT_LBU   = 6'd14, OPT_LHU   = 6'd15,
    OPT_SB    = 6'd16, OPT_SH    = 6'd17, OPT_SW    = 6'd18, OPT_ADDI  = 6'd19,
    OPT_SLTI  = 6'd20, OPT_SLTIU = 6'd21, OPT_XORI  = 6'd22, OPT_ORI   = 6'd23,
    OPT_ANDI  = 6'd24, OPT_SLLI  = 6'd25, OPT_SRLI  = 6'd26, OPT_SRAI  = 6'd27,
    OPT_ADD   = 6'd28, OPT_SUB   = 6'd29, OPT_SLL   = 6'd30, OPT_SLT   = 6'd31,
    OPT_SLTU  = 6'd32, OPT_XOR   = 6'd33, OPT_SRL   = 6'd34, OPT_SRA   = 6'd35,
    OPT_OR    = 6'd36, OPT_AND   = 6'd37
  } optype_e;

  typedef struct packed {
    optype_e     optype;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } decoded_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        predict;
    decoded_t    dec;
  } iq_entry_t;

  // Register fields an instruction format does not use are zeroed so consumers
  // never see false dependencies.
  function automatic decoded_t decode(input logic [31:0] inst);
    decoded_t d;
    logic [2:0] f3;
    f3       = inst[14:12];
    d.optype = OPT_NONE;
    d.rs1    = inst[19:15];
    d.rs2    = inst[24:20];
    d.rd     = inst[11:7];
    d.imm    = '0;
    case (inst[6:0])
      LUIOP, AUIPCOP: begin
        d.optype = (inst[6:0] == LUIOP) ? OPT_LUI : OPT_AUIPC;
        d.rs1    = '0;
        d.rs2    = '0;
        d.imm    = {inst[31:12], 12'b0};
      end
      JALOP: begin
        d.optype = OPT_JAL;
        d.rs1    = '0;
        d.rs2    = '0;
        d.imm    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      JALROP: begin
        d.optype = OPT_JALR;
        d.rs2    = '0;
        d.imm    = {{20{inst[31]}}, inst[31:20]};
      end
      BOP: begin
        d.rd  = '0;
        d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        case (f3)
          3'b000:  d.optype = OPT_BEQ;
          3'b001:  d.optype = OPT_BNE;
          3'b100:  d.optype = OPT_BLT;
          3'b101:  d.optype = OPT_BGE;
          3'b110:  d.optype = OPT_BLTU;
          3'b111:  d.optype = OPT_BGEU;
          default: d.optype = OPT_NONE;
        endcase
      end
      LOADOP: begin
        d.rs2 = '0;
        d.imm = {{20{inst[31]}}, inst[31:20]};
        case (f3)
          3'b000:  d.optype = OPT_LB;
          3'b001:  d.optype = OPT_LH;
          3'b010:  d.optype = OPT_LW;
          3'b100:  d.optype = OPT_LBU;
          3'b101:  d.optype = OPT_LHU;
          default: d.optype = OPT_NONE;
        endcase
      end
      STOREOP: begin
        d.rd  = '0;
        d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        case (f3)
          3'b000:  d.optype = OPT_SB;
          3'b001:  d.optype = OPT_SH;
          3'b010:  d.optype = OPT_SW;
          default: d.optype = OPT_NONE;
        endcase
      end
      IMMOP: begin
        d.rs2 = '0;
        d.imm = {{20{inst[31]}}, inst[31:20]};
        case (f3)
          3'b000: d.optype = OPT_ADDI;
          3'b010: d.optype = OPT_SLTI;
          3'b011: d.optype = OPT_SLTIU;
          3'b100: d.optype = OPT_XORI;
          3'b110: d.optype = OPT_ORI;
          3'b111: d.optype = OPT_ANDI;
          3'b001: begin
            d.optype = OPT_SLLI;
            d.imm    = {27'b0, inst[24:20]};
          end
          default: begin
            if (inst[30]) d.optype = OPT_SRAI;
            else          d.optype = OPT_SRLI;
            d.imm = {27'b0, inst[24:20]};
          end
        endcase
      end
      REGOP: begin
        case (f3)
          3'b000: begin
            if (inst[30]) d.optype = OPT_SUB;
            else          d.optype = OPT_ADD;
          end
          3'b001: d.optype = OPT_SLL;
          3'b010: d.optype = OPT_SLT;
          3'b011: d.optype = OPT_SLTU;
          3'b100: d.optype = OPT_XOR;
          3'b101: begin
            if (inst[30]) d.optype = OPT_SRA;
            else          d.optype = OPT_SRL;
          end
          3'b110: d.optype = OPT_OR;
          default: d.optype = OPT_AND;
        endcase
      end
      default: begin
        d.rs1 = '0;
        d.rs2 = '0;
        d.rd  = '0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Circular FIFO of decoded fetch entries with flush; the head entry is presented
// straight from storage so issue outputs never depend on the icache this cycle.
module ifetch_queue
  import ifetch_queue_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  iq_entry_t        push_entry,
  input  logic             pop,
  input  logic             flush,
  output iq_entry_t        head_entry,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  iq_entry_t        mem_q [DEPTH];
  iq_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = push_entry;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (do_pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;

endmodule

// File: rtl/ifetch_queue_unit.sv
// Instruction fetcher: owns the fetch PC and JALR stall, decodes icache words and
// buffers them in an issue queue so fetch keeps running under issue back-pressure.
module ifetch_queue_unit
  import ifetch_queue_unit_pkg::*;
#(
  parameter int          IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  output logic [31:0]                pc_to_icache,
  input  logic                       icache_hit,
  input  logic [31:0]                icache_inst,
  output logic [31:0]                bp_pc,
  input  logic                       bp_taken,
  input  logic                       issue_ready,
  output logic                       issue_valid,
  output logic [31:0]                issue_pc,
  output logic                       issue_predict,
  output logic [5:0]                 issue_optype,
  output logic [4:0]                 issue_rs1,
  output logic [4:0]                 issue_rs2,
  output logic [4:0]                 issue_rd,
  output logic [31:0]                issue_imm,
  input  logic                       jalr_valid,
  input  logic [31:0]                jalr_pc,
  input  logic                       rollback,
  input  logic [31:0]                rollback_pc,
  output logic [$clog2(IQ_DEPTH):0]  iq_count
);

  localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

  logic [31:0]      pc_q, pc_d;
  logic             jalr_wait_q, jalr_wait_d;
  decoded_t         fetch_dec;
  logic [6:0]       fetch_opcode;
  iq_entry_t        push_entry;
  iq_entry_t        head_entry;
  logic             push;
  logic             pop;
  logic             flush;
  logic             iq_empty;
  logic             iq_full;
  logic [CNT_W-1:0] count;

  assign fetch_dec    = decode(icache_inst);
  assign fetch_opcode = icache_inst[6:0];

  // A full queue refuses the push even if the head pops this same cycle.
  assign push  = rdy & ~rollback & ~jalr_valid & ~jalr_wait_q & icache_hit & ~iq_full;
  assign issue_valid = rdy & ~iq_empty;
  assign pop   = issue_valid & issue_ready & ~rollback;
  assign flush = rdy & rollback;

  assign push_entry = '{pc: pc_q, predict: bp_taken, dec: fetch_dec};

  ifetch_queue #(
    .DEPTH (IQ_DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head_entry (head_entry),
    .count      (count),
    .empty      (iq_empty),
    .full       (iq_full)
  );

  // Redirect priority: rollback, then the ALU's JALR target, then the fetch path.
  always_comb begin
    pc_d        = pc_q;
    jalr_wait_d = jalr_wait_q;
    if (rdy) begin
      if (rollback) begin
        pc_d        = rollback_pc;
        jalr_wait_d = 1'b0;
      end else if (jalr_valid) begin
        pc_d        = jalr_pc;
        jalr_wait_d = 1'b0;
      end else if (push) begin
        if ((fetch_opcode == BOP && bp_taken) || fetch_opcode == JALOP) begin
          pc_d = pc_q + fetch_dec.imm;
        end else if (fetch_opcode == JALROP) begin
          jalr_wait_d = 1'b1;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      jalr_wait_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      jalr_wait_q <= jalr_wait_d;
    end
  end

  assign pc_to_icache  = pc_q;
  assign bp_pc         = pc_q;
  assign issue_pc      = head_entry.pc;
  assign issue_predict = head_entry.predict;
  assign issue_optype  = head_entry.dec.optype;
  assign issue_rs1     = head_entry.dec.rs1;
  assign issue_rs2     = head_entry.dec.rs2;
  assign issue_rd      = head_entry.dec.rd;
  assign issue_imm     = head_entry.dec.imm;
  assign iq_count      = count;

endmodule

// File: tb/tb_ifetch_queue_unit.sv
// Scoreboard bench for ifetch_queue_unit: a behavioural PC/queue model pushes the
// expected decoded entry on each accepted fetch and pops it when the DUT issues.
module tb_ifetch_queue_unit;

  localparam int IQ_DEPTH = 4;
  localparam int CNT_W    = $clog2(IQ_DEPTH) + 1;
  localparam int K_PLAIN  = 0;
  localparam int K_BRANCH = 1;
  localparam int K_JALR   = 2;

  logic             clk = 1'b0;
  logic             rst, rdy, icache_hit, bp_taken, issue_ready, jalr_valid, rollback;
  logic [31:0]      icache_inst, jalr_pc, rollback_pc;
  logic [31:0]      pc_to_icache, bp_pc, issue_pc, issue_imm;
  logic             issue_valid, issue_predict;
  logic [5:0]       issue_optype;
  logic [4:0]       issue_rs1, issue_rs2, issue_rd;
  logic [CNT_W-1:0] iq_count;

  typedef struct {
    logic [31:0] pc;
    logic        predict;
    logic [5:0]  optype;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    int          kind;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc;
  bit          m_wait;
  bit          jalr_at_8;
  int          compared = 0;
  int          mismatched = 0;

  ifetch_queue_unit #(.IQ_DEPTH(IQ_DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc_to_icache(pc_to_icache),
    .icache_hit(icache_hit), .icache_inst(icache_inst), .bp_pc(bp_pc),
    .bp_taken(bp_taken), .issue_ready(issue_ready), .issue_valid(issue_valid),
    .issue_pc(issue_pc), .issue_predict(issue_predict), .issue_optype(issue_optype),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_imm(issue_imm), .jalr_valid(jalr_valid), .jalr_pc(jalr_pc),
    .rollback(rollback), .rollback_pc(rollback_pc), .iq_count(iq_count)
  );

  always #5 clk = ~clk;

  // Program image: ADDI x1,x0,pc>>2 everywhere, BEQ x1,x2,+0x20 at 0x10, optional JALR at 0x8.
  function automatic void lookup(input logic [31:0] pc, output logic [31:0] inst, output exp_t e);
    logic [11:0] k;
    k         = pc[13:2];
    e.pc      = pc;
    e.predict = 1'b0;
    if (pc == 32'h10) begin
      inst     = {1'b0, 6'b000001, 5'd2, 5'd1, 3'b000, 4'b0000, 1'b0, 7'b1100011};
      e.optype = 6'd5; e.rd = 5'd0; e.rs1 = 5'd1; e.rs2 = 5'd2; e.imm = 32'h20;
      e.kind   = K_BRANCH;
    end else if (jalr_at_8 && pc == 32'h8) begin
      inst     = {12'd0, 5'd5, 3'b000, 5'd1, 7'b1100111};
      e.optype = 6'd4; e.rd = 5'd1; e.rs1 = 5'd5; e.rs2 = 5'd0; e.imm = 32'h0;
      e.kind   = K_JALR;
    end else begin
      inst     = {k, 5'd0, 3'b000, 5'd1, 7'b0010011};
      e.optype = 6'd19; e.rd = 5'd1; e.rs1 = 5'd0; e.rs2 = 5'd0; e.imm = {20'd0, k};
      e.kind   = K_PLAIN;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1; rdy = 1'b1; icache_hit = 1'b0; bp_taken = 1'b0; issue_ready = 1'b0;
    jalr_valid = 1'b0; rollback = 1'b0; jalr_pc = '0; rollback_pc = '0; icache_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_pc = 32'h0; m_wait = 1'b0; jalr_at_8 = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs against the model, then advance the model.
  task automatic applyStimulus(input bit r, input bit hit, input bit ready, input bit bp,
                               input bit jv, input logic [31:0] jpc,
                               input bit rb, input logic [31:0] rbpc);
    exp_t        e, f;
    logic [31:0] inst;
    int          occ;
    bit          do_pop, do_push;
    rdy = r; icache_hit = hit; issue_ready = ready; bp_taken = bp;
    jalr_valid = jv; jalr_pc = jpc; rollback = rb; rollback_pc = rbpc;
    lookup(pc_to_icache, inst, e);
    icache_inst = inst;
    #1;
    occ = exp_q.size();
    checkOutput("pc_to_icache", pc_to_icache, m_pc);
    checkOutput("bp_pc", bp_pc, m_pc);
    checkOutput("iq_count", 32'(iq_count), 32'(occ));
    checkOutput("issue_valid", 32'(issue_valid), 32'(r && occ != 0));
    do_pop = r && occ != 0 && ready && !rb;
    if (do_pop) begin
      f = exp_q.pop_front();
      checkOutput("issue_pc", issue_pc, f.pc);
      checkOutput("issue_predict", 32'(issue_predict), 32'(f.predict));
      checkOutput("issue_optype", 32'(issue_optype), 32'(f.optype));
      checkOutput("issue_rd", 32'(issue_rd), 32'(f.rd));
      checkOutput("issue_rs1", 32'(issue_rs1), 32'(f.rs1));
      checkOutput("issue_rs2", 32'(issue_rs2), 32'(f.rs2));
      checkOutput("issue_imm", issue_imm, f.imm);
    end
    if (r) begin
      if (rb) begin
        exp_q.delete();
        m_pc   = rbpc;
        m_wait = 1'b0;
      end else if (jv) begin
        m_pc   = jpc;
        m_wait = 1'b0;
      end else begin
        do_push = !m_wait && hit && occ < IQ_DEPTH;
        if (do_push) begin
          lookup(m_pc, inst, e);
          e.predict = bp;
          exp_q.push_back(e);
          if (e.kind == K_BRANCH && bp) m_pc = m_pc + e.imm;
          else if (e.kind == K_JALR)    m_wait = 1'b1;
          else                          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Straight-line fetch with the consumer always ready.
    resetDut();
    repeat (4) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);

    // Back-pressure fills the queue, then the predicted-taken BEQ at 0x10 redirects to 0x30.
    resetDut();
    repeat (6) applyStimulus(1, 1, 0, 1, 0, 0, 0, 0);
    repeat (3) applyStimulus(1, 1, 1, 1, 0, 0, 0, 0);
    repeat (6) applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);

    // Not-taken BEQ falls through to 0x14.
    resetDut();
    repeat (6) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);

    // JALR stall, freeze while stalled, ALU redirect, then an unsolicited redirect.
    resetDut();
    jalr_at_8 = 1'b1;
    repeat (6) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (2) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 1, 32'h100, 0, 0);
    repeat (3) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 32'h200, 0, 0);
    repeat (2) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    repeat (4) applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);

    // Rollback with three entries queued, then rollback beating jalr_valid.
    resetDut();
    repeat (3) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 1, 32'h40);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 1, 32'h200, 1, 32'h40);
    repeat (2) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);

    // Global freeze mid-stream.
    resetDut();
    repeat (2) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 1, 1, 0, 1, 32'h300, 1, 32'h80);
    repeat (2) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    repeat (4) applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
